// File: rtl/axi4_r_demux_buf.sv
// axi4_r_demux_buf: AXI4 R-channel demultiplexing buffer.
// Each slave-side beat is steered to the master given by the upper ID bits.
// Those bits are stripped, and the beat is held in a per-master FIFO.
// Optional feature macro: AXI4_RBUF_BYPASS_EN (zero-latency pass-through
// when the target FIFO is empty and the master is ready).
module axi4_r_demux_buf #(
   parameter int NUM     = 4,
   parameter int ID_W    = 4,
   parameter int EXTRA_W = $clog2(NUM),
   parameter int DATA_W  = 64,
   parameter int DEPTH   = 2
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [EXTRA_W+ID_W-1:0] S_RID,
   input  logic [DATA_W-1:0]       S_RDATA,
   input  logic [DATA_W/8-1:0]     S_RSTRB,
   input  logic                    S_RLAST,
   input  logic                    S_RVALID,
   output logic                    S_RREADY,
   output logic [ID_W-1:0]         M_RID    [0:NUM-1],
   output logic [DATA_W-1:0]       M_RDATA  [0:NUM-1],
   output logic [DATA_W/8-1:0]     M_RSTRB  [0:NUM-1],
   output logic                    M_RLAST  [0:NUM-1],
   output logic                    M_RVALID [0:NUM-1],
   input  logic                    M_RREADY [0:NUM-1],
   output logic                    ERR_DROP
);

   localparam int          STRB_W  = DATA_W / 8;
   localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CNT_W   = $clog2(DEPTH + 1);
   localparam logic [31:0] NUM_U   = NUM;
   localparam logic [31:0] DEPTH_U = DEPTH;

   logic [EXTRA_W-1:0] tgt;
   logic [ID_W-1:0]    sid;
   logic               in_range;
   logic               tgt_full;

   logic               sel   [NUM];
   logic               full  [NUM];
   logic               push  [NUM];
   logic               pop   [NUM];
`ifdef AXI4_RBUF_BYPASS_EN
   logic               byp   [NUM];
`endif

   logic [CNT_W-1:0]   count [NUM];
   logic [PTR_W-1:0]   wptr  [NUM];
   logic [PTR_W-1:0]   rptr  [NUM];
   logic               err_drop_q;

   logic [ID_W-1:0]    mem_id   [NUM][DEPTH];
   logic [DATA_W-1:0]  mem_data [NUM][DEPTH];
   logic [STRB_W-1:0]  mem_strb [NUM][DEPTH];
   logic               mem_last [NUM][DEPTH];

   assign tgt      = S_RID[EXTRA_W+ID_W-1:ID_W];
   assign sid      = S_RID[ID_W-1:0];
   assign ERR_DROP = err_drop_q;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH_U - 32'd1) ? '0 : p + PTR_W'(1);
   endfunction

   // Decode target, derive per-FIFO push/pop and the slave-side ready.
   always_comb begin
      in_range = (32'(tgt) < NUM_U);
      tgt_full = 1'b0;
      for (int unsigned i = 0; i < NUM_U; i++) begin
         sel[i]  = (32'(tgt) == i);
         full[i] = (count[i] == CNT_W'(DEPTH));
         pop[i]  = (count[i] != '0) && M_RREADY[i];
`ifdef AXI4_RBUF_BYPASS_EN
         byp[i]  = sel[i] && (count[i] == '0) && M_RREADY[i];
         push[i] = S_RVALID && sel[i] && !full[i] && !byp[i];
`else
         push[i] = S_RVALID && sel[i] && !full[i];
`endif
         if (sel[i] && full[i]) tgt_full = 1'b1;
      end
      S_RREADY = !in_range || !tgt_full;
   end

   // Per-master pointers and occupancy; drop flag for out-of-range beats.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int unsigned i = 0; i < NUM_U; i++) begin
            count[i] <= '0;
            wptr[i]  <= '0;
            rptr[i]  <= '0;
         end
         err_drop_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_U; i++) begin
            if (push[i]) wptr[i] <= next_ptr(wptr[i]);
            if (pop[i])  rptr[i] <= next_ptr(rptr[i]);
            if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
            else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
         end
         err_drop_q <= S_RVALID && !in_range;
      end
   end

   // Beat storage; contents need no reset because count gates visibility.
   always_ff @(posedge ACLK) begin
      for (int unsigned i = 0; i < NUM_U; i++) begin
         if (push[i]) begin
            mem_id[i][wptr[i]]   <= sid;
            mem_data[i][wptr[i]] <= S_RDATA;
            mem_strb[i][wptr[i]] <= S_RSTRB;
            mem_last[i][wptr[i]] <= S_RLAST;
         end
      end
   end

   // Master-side outputs present the FIFO head (or the live beat on bypass).
   always_comb begin
      for (int unsigned i = 0; i < NUM_U; i++) begin
         M_RVALID[i] = (count[i] != '0);
         M_RID[i]    = mem_id[i][rptr[i]];
         M_RDATA[i]  = mem_data[i][rptr[i]];
         M_RSTRB[i]  = mem_strb[i][rptr[i]];
         M_RLAST[i]  = mem_last[i][rptr[i]];
`ifdef AXI4_RBUF_BYPASS_EN
         if (byp[i]) begin
            M_RVALID[i] = S_RVALID;
            M_RID[i]    = sid;
            M_RDATA[i]  = S_RDATA;
            M_RSTRB[i]  = S_RSTRB;
            M_RLAST[i]  = S_RLAST;
         end
`endif
      end
   end

endmodule

// File: tb/tb_axi4_r_demux_buf.sv
// Self-checking bench for axi4_r_demux_buf: vector table, directed
// sequences (reset mid-burst, out-of-range drop, non-power-of-two depth)
// and randomized traffic against a queue-based reference model.
module tb_axi4_r_demux_buf;

   logic clk = 1'b0;
   logic areset;
   always #5 clk = ~clk;

   // NUM=4, DEPTH=2 instance
   logic [5:0]  s_rid;
   logic [63:0] s_rdata;
   logic [7:0]  s_rstrb;
   logic        s_rlast, s_rvalid, s_rready;
   logic [3:0]  m_rid    [0:3];
   logic [63:0] m_rdata  [0:3];
   logic [7:0]  m_rstrb  [0:3];
   logic        m_rlast  [0:3];
   logic        m_rvalid [0:3];
   logic        m_rready [0:3];
   logic        err_drop;

   // NUM=3, DEPTH=3 instance
   logic [5:0]  s3_rid;
   logic [63:0] s3_rdata;
   logic [7:0]  s3_rstrb;
   logic        s3_rlast, s3_rvalid, s3_rready;
   logic [3:0]  m3_rid    [0:2];
   logic [63:0] m3_rdata  [0:2];
   logic [7:0]  m3_rstrb  [0:2];
   logic        m3_rlast  [0:2];
   logic        m3_rvalid [0:2];
   logic        m3_rready [0:2];
   logic        err3_drop;

   axi4_r_demux_buf #(.NUM(4), .ID_W(4), .DATA_W(64), .DEPTH(2)) dut (
      .ACLK(clk), .ARESET(areset),
      .S_RID(s_rid), .S_RDATA(s_rdata), .S_RSTRB(s_rstrb), .S_RLAST(s_rlast),
      .S_RVALID(s_rvalid), .S_RREADY(s_rready),
      .M_RID(m_rid), .M_RDATA(m_rdata), .M_RSTRB(m_rstrb), .M_RLAST(m_rlast),
      .M_RVALID(m_rvalid), .M_RREADY(m_rready), .ERR_DROP(err_drop));

   axi4_r_demux_buf #(.NUM(3), .ID_W(4), .DATA_W(64), .DEPTH(3)) dut3 (
      .ACLK(clk), .ARESET(areset),
      .S_RID(s3_rid), .S_RDATA(s3_rdata), .S_RSTRB(s3_rstrb), .S_RLAST(s3_rlast),
      .S_RVALID(s3_rvalid), .S_RREADY(s3_rready),
      .M_RID(m3_rid), .M_RDATA(m3_rdata), .M_RSTRB(m3_rstrb), .M_RLAST(m3_rlast),
      .M_RVALID(m3_rvalid), .M_RREADY(m3_rready), .ERR_DROP(err3_drop));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] mv_mask();
      return {m_rvalid[3], m_rvalid[2], m_rvalid[1], m_rvalid[0]};
   endfunction

   function automatic logic [2:0] mv3_mask();
      return {m3_rvalid[2], m3_rvalid[1], m3_rvalid[0]};
   endfunction

   task automatic set_rdy(input logic [3:0] r);
      for (int i = 0; i < 4; i++) m_rready[i] = r[i];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0]  rid;
      logic        vld;
      logic [63:0] data;
      logic        last;
      logic [3:0]  rdy;
      logic        exp_srdy;
      logic [3:0]  exp_mv;
      int          chk_m;
      logic [3:0]  exp_id;
      logic [63:0] exp_data;
      logic        exp_last;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] rid, input logic vld, input logic [63:0] data,
                               input logic last, input logic [3:0] rdy, input logic exp_srdy,
                               input logic [3:0] exp_mv, input int chk_m, input logic [3:0] exp_id,
                               input logic [63:0] exp_data, input logic exp_last);
      vec_t v;
      v.rid = rid; v.vld = vld; v.data = data; v.last = last; v.rdy = rdy;
      v.exp_srdy = exp_srdy; v.exp_mv = exp_mv; v.chk_m = chk_m;
      v.exp_id = exp_id; v.exp_data = exp_data; v.exp_last = exp_last;
      return v;
   endfunction

   typedef struct {
      logic [3:0]  id;
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } beat_t;

   beat_t mq [4][$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [16];

      areset = 1'b1;
      s_rid = '0; s_rdata = '0; s_rstrb = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
      s3_rid = '0; s3_rdata = '0; s3_rstrb = '0; s3_rlast = 1'b0; s3_rvalid = 1'b0;
      set_rdy(4'b0000);
      for (int i = 0; i < 3; i++) m3_rready[i] = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_mvalid", 64'(mv_mask()), 64'h0);
      chk("reset_err", 64'(err_drop), 64'h0);
      chk("reset_srdy", 64'(s_rready), 64'h1);
      chk("reset_mvalid3", 64'(mv3_mask()), 64'h0);
      areset = 1'b0;
      tick();

`ifdef AXI4_RBUF_BYPASS_EN
      // Zero-latency pass-through on empty FIFO with ready master.
      set_rdy(4'b0001);
      s_rid = 6'h09; s_rdata = 64'hB1B1_0000_DEAD_BEEF; s_rstrb = 8'h5A; s_rlast = 1'b1; s_rvalid = 1'b1;
      #1;
      chk("byp_valid", 64'(m_rvalid[0]), 64'h1);
      chk("byp_data", m_rdata[0], 64'hB1B1_0000_DEAD_BEEF);
      chk("byp_id", 64'(m_rid[0]), 64'h9);
      chk("byp_strb", 64'(m_rstrb[0]), 64'h5A);
      chk("byp_last", 64'(m_rlast[0]), 64'h1);
      chk("byp_srdy", 64'(s_rready), 64'h1);
      @(posedge clk); #1;
      s_rvalid = 1'b0;
      #1;
      chk("byp_count0", 64'(mv_mask()), 64'h0);
      tick();
`else
      // Burst to master 2, stall master 1 to full, independence via master 3.
      tbl[0]  = mk(6'h25, 1, 64'hA0, 0, 4'b0100, 1, 4'b0000, -1, 4'h0, 64'h0, 0);
      tbl[1]  = mk(6'h25, 1, 64'hA1, 0, 4'b0100, 1, 4'b0100,  2, 4'h5, 64'hA0, 0);
      tbl[2]  = mk(6'h25, 1, 64'hA2, 0, 4'b0100, 1, 4'b0100,  2, 4'h5, 64'hA1, 0);
      tbl[3]  = mk(6'h25, 1, 64'hA3, 1, 4'b0100, 1, 4'b0100,  2, 4'h5, 64'hA2, 0);
      tbl[4]  = mk(6'h00, 0, 64'h0,  0, 4'b0100, 1, 4'b0100,  2, 4'h5, 64'hA3, 1);
      tbl[5]  = mk(6'h00, 0, 64'h0,  0, 4'b0000, 1, 4'b0000, -1, 4'h0, 64'h0, 0);
      tbl[6]  = mk(6'h13, 1, 64'hB0, 0, 4'b0000, 1, 4'b0000, -1, 4'h0, 64'h0, 0);
      tbl[7]  = mk(6'h13, 1, 64'hB1, 0, 4'b0000, 1, 4'b0010,  1, 4'h3, 64'hB0, 0);
      tbl[8]  = mk(6'h13, 1, 64'hB2, 1, 4'b0000, 0, 4'b0010,  1, 4'h3, 64'hB0, 0);
      tbl[9]  = mk(6'h37, 1, 64'hC0, 1, 4'b1000, 1, 4'b0010,  1, 4'h3, 64'hB0, 0);
      tbl[10] = mk(6'h13, 1, 64'hB2, 1, 4'b1000, 0, 4'b1010,  3, 4'h7, 64'hC0, 1);
      tbl[11] = mk(6'h13, 1, 64'hB2, 1, 4'b0010, 0, 4'b0010,  1, 4'h3, 64'hB0, 0);
      tbl[12] = mk(6'h13, 1, 64'hB2, 1, 4'b0000, 1, 4'b0010,  1, 4'h3, 64'hB1, 0);
      tbl[13] = mk(6'h00, 0, 64'h0,  0, 4'b0010, 1, 4'b0010,  1, 4'h3, 64'hB1, 0);
      tbl[14] = mk(6'h00, 0, 64'h0,  0, 4'b0010, 1, 4'b0010,  1, 4'h3, 64'hB2, 1);
      tbl[15] = mk(6'h00, 0, 64'h0,  0, 4'b0000, 1, 4'b0000, -1, 4'h0, 64'h0, 0);

      for (int n = 0; n < 16; n++) begin
         s_rid = tbl[n].rid; s_rvalid = tbl[n].vld; s_rdata = tbl[n].data;
         s_rlast = tbl[n].last; s_rstrb = 8'hFF;
         set_rdy(tbl[n].rdy);
         #4;
         chk($sformatf("tbl%0d_srdy", n), 64'(s_rready), 64'(tbl[n].exp_srdy));
         chk($sformatf("tbl%0d_mvalid", n), 64'(mv_mask()), 64'(tbl[n].exp_mv));
         chk($sformatf("tbl%0d_err", n), 64'(err_drop), 64'h0);
         if (tbl[n].chk_m >= 0) begin
            chk($sformatf("tbl%0d_id", n), 64'(m_rid[tbl[n].chk_m]), 64'(tbl[n].exp_id));
            chk($sformatf("tbl%0d_data", n), m_rdata[tbl[n].chk_m], tbl[n].exp_data);
            chk($sformatf("tbl%0d_last", n), 64'(m_rlast[tbl[n].chk_m]), 64'(tbl[n].exp_last));
         end
         @(posedge clk); #1;
      end

      // Reset mid-burst discards buffered beats immediately.
      set_rdy(4'b0000);
      s_rid = 6'h01; s_rvalid = 1'b1; s_rdata = 64'h51; s_rlast = 1'b0;
      tick();
      s_rdata = 64'h52;
      tick();
      s_rvalid = 1'b0;
      #2;
      chk("rst_pre_valid", 64'(m_rvalid[0]), 64'h1);
      areset = 1'b1;
      #1;
      chk("rst_async_valid", 64'(mv_mask()), 64'h0);
      @(negedge clk);
      areset = 1'b0;
      tick();
      s_rid = 6'h02; s_rvalid = 1'b1; s_rdata = 64'h6060; s_rlast = 1'b1;
      tick();
      s_rvalid = 1'b0;
      #1;
      chk("rst_new_valid", 64'(m_rvalid[0]), 64'h1);
      chk("rst_new_data", m_rdata[0], 64'h6060);
      chk("rst_new_id", 64'(m_rid[0]), 64'h2);
      set_rdy(4'b0001);
      tick();
      chk("rst_no_stale", 64'(m_rvalid[0]), 64'h0);
      set_rdy(4'b0000);

      // Out-of-range target on NUM=3 is accepted and dropped.
      s3_rid = 6'h3A; s3_rvalid = 1'b1; s3_rdata = 64'hEE;
      #4;
      chk("drop_srdy", 64'(s3_rready), 64'h1);
      @(posedge clk); #1;
      s3_rvalid = 1'b0;
      chk("drop_err_pulse", 64'(err3_drop), 64'h1);
      chk("drop_no_valid", 64'(mv3_mask()), 64'h0);
      tick();
      chk("drop_err_clear", 64'(err3_drop), 64'h0);
      chk("drop_no_valid2", 64'(mv3_mask()), 64'h0);

      // DEPTH=3 fill, full stall, pointer wrap and in-order drain.
      s3_rid = 6'h21; s3_rvalid = 1'b1; s3_rdata = 64'hD0;
      tick();
      s3_rdata = 64'hD1;
      tick();
      s3_rdata = 64'hD2;
      tick();
      s3_rdata = 64'hD3;
      #4;
      chk("d3_full_srdy", 64'(s3_rready), 64'h0);
      chk("d3_head0", m3_rdata[2], 64'hD0);
      @(posedge clk); #1;
      s3_rvalid = 1'b0; m3_rready[2] = 1'b1;
      tick();
      m3_rready[2] = 1'b0; s3_rvalid = 1'b1;
      #4;
      chk("d3_after_pop_srdy", 64'(s3_rready), 64'h1);
      @(posedge clk); #1;
      s3_rvalid = 1'b0; m3_rready[2] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         #4;
         chk($sformatf("d3_drain%0d_valid", k), 64'(m3_rvalid[2]), 64'h1);
         chk($sformatf("d3_drain%0d_data", k), m3_rdata[2], 64'hD0 + 64'(k));
         chk($sformatf("d3_drain%0d_id", k), 64'(m3_rid[2]), 64'h1);
         @(posedge clk); #1;
      end
      chk("d3_empty", 64'(mv3_mask()), 64'h0);
      m3_rready[2] = 1'b0;

      // Randomized traffic against the queue model (all FIFOs empty here).
      for (int n = 0; n < 400; n++) begin
         logic [1:0] t;
         logic       exp_srdy;
         logic [3:0] rdy;
         s_rid    = 6'($urandom_range(0, 63));
         s_rvalid = 1'($urandom_range(0, 3) != 0);
         s_rdata  = {$urandom, $urandom};
         s_rstrb  = 8'($urandom);
         s_rlast  = 1'($urandom);
         rdy      = 4'($urandom);
         set_rdy(rdy);
         #4;
         t = s_rid[5:4];
         exp_srdy = (mq[t].size() != 2);
         chk("rnd_srdy", 64'(s_rready), 64'(exp_srdy));
         chk("rnd_err", 64'(err_drop), 64'h0);
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("rnd_valid%0d", i), 64'(m_rvalid[i]), 64'(mq[i].size() != 0));
            if (mq[i].size() != 0) begin
               chk($sformatf("rnd_id%0d", i), 64'(m_rid[i]), 64'(mq[i][0].id));
               chk($sformatf("rnd_data%0d", i), m_rdata[i], mq[i][0].data);
               chk($sformatf("rnd_strb%0d", i), 64'(m_rstrb[i]), 64'(mq[i][0].strb));
               chk($sformatf("rnd_last%0d", i), 64'(m_rlast[i]), 64'(mq[i][0].last));
            end
         end
         begin
            logic do_push;
            beat_t b;
            do_push = s_rvalid && exp_srdy;
            b.id = s_rid[3:0]; b.data = s_rdata; b.strb = s_rstrb; b.last = s_rlast;
            for (int i = 0; i < 4; i++)
               if (mq[i].size() != 0 && rdy[i]) void'(mq[i].pop_front());
            if (do_push) mq[t].push_back(b);
         end
         @(posedge clk); #1;
      end
      s_rvalid = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
